// File: rtl/md_unit_if.sv
// Request/result bundle between the EX-stage controller and the multiply/divide unit.
// The controller holds the master side; md_unit holds the slave side.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// MIPS multiply/divide unit: MULT/MULTU/DIV/DIVU with fixed latency, architectural HI/LO
// and MTHI/MTLO writes. Results come from the operands latched at issue.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset_n,
    md_unit_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES    = {WIDTH{1'b1}};

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + W_ONE;
    endfunction

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [WIDTH-1:0]   opa_r, opa_s;
    logic [WIDTH-1:0]   opb_r, opb_s;
    logic [1:0]         op_r, op_s;
    logic [WIDTH-1:0]   hi_r, hi_s;
    logic [WIDTH-1:0]   lo_r, lo_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    logic               is_signed_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [2*WIDTH-1:0] mul_a_s;
    logic [2*WIDTH-1:0] mul_b_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   uquot_s;
    logic [WIDTH-1:0]   urem_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Result datapath on the latched operands; bit 0 of the op selects unsigned.
    always_comb begin
        is_signed_s = ~op_r[0];
        a_neg_s     = is_signed_s & opa_r[WIDTH-1];
        b_neg_s     = is_signed_s & opb_r[WIDTH-1];

        // Sign/zero-extend to 2*WIDTH so one multiplier serves both flavours.
        mul_a_s   = {{WIDTH{a_neg_s}}, opa_r};
        mul_b_s   = {{WIDTH{b_neg_s}}, opb_r};
        product_s = mul_a_s * mul_b_s;

        // Divide on magnitudes, then restore signs: quotient toward zero,
        // remainder follows the dividend. MIN / -1 falls out as MIN rem 0.
        mag_a_s = a_neg_s ? negate(opa_r) : opa_r;
        mag_b_s = b_neg_s ? negate(opb_r) : opb_r;
        uquot_s = mag_a_s / mag_b_s;
        urem_s  = mag_a_s % mag_b_s;

        if (op_r[1]) begin
            if (opb_r == W_ZERO) begin
                res_hi_s = opa_r;
                res_lo_s = W_ONES;
            end else begin
                res_hi_s = a_neg_s ? negate(urem_s) : urem_s;
                res_lo_s = (a_neg_s ^ b_neg_s) ? negate(uquot_s) : uquot_s;
            end
        end else begin
            res_hi_s = product_s[2*WIDTH-1:WIDTH];
            res_lo_s = product_s[WIDTH-1:0];
        end
    end

    // Next-state and next-register decode; requests are only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        opa_s   = opa_r;
        opb_s   = opb_r;
        op_s    = op_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        busy_s  = busy_r;
        done_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (md.start) begin
                    case (md.op)
                        OP_MULT, OP_MULTU: begin
                            opa_s   = md.a;
                            opb_s   = md.b;
                            op_s    = md.op[1:0];
                            cnt_s   = MULT_LOAD;
                            busy_s  = 1'b1;
                            state_s = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_s   = md.a;
                            opb_s   = md.b;
                            op_s    = md.op[1:0];
                            cnt_s   = DIV_LOAD;
                            busy_s  = 1'b1;
                            state_s = RUN;
                        end
                        OP_MTHI: hi_s = md.a;
                        OP_MTLO: lo_s = md.a;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    hi_s    = res_hi_s;
                    lo_s    = res_lo_s;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= {CW{1'b0}};
            opa_r  <= W_ZERO;
            opb_r  <= W_ZERO;
            op_r   <= 2'b00;
            hi_r   <= W_ZERO;
            lo_r   <= W_ZERO;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            opa_r  <= opa_s;
            opb_r  <= opb_s;
            op_r   <= op_s;
            hi_r   <= hi_s;
            lo_r   <= lo_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    assign md.busy = busy_r;
    assign md.done = done_r;
    assign md.hi   = hi_r;
    assign md.lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, hand sequences for
// done-cycle issue / ignored requests / reset abort, and random ops against a model.
module tb_md_unit;
    localparam int W = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset_n;
    md_unit_if #(.WIDTH(W)) bus ();

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .md(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic plus the architectural special cases.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy;
        longint unsigned ux, uy;
        int qi, ri, xi, yi;
        case (op)
            3'd0: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return 64'(sx * sy);
            end
            3'd1: begin
                ux = {32'h0, x};
                uy = {32'h0, y};
                return ux * uy;
            end
            3'd2: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                xi = x;
                yi = y;
                qi = xi / yi;
                ri = xi % yi;
                return {ri, qi};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one MULT/DIV starting just after an edge; returns in the done cycle.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                          input int en, input bit inj);
        int n;
        bit held;
        bus.start = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        held = 1'b1;
        while (bus.busy === 1'b1 && n < 64) begin
            n++;
            if (bus.hi !== m_hi || bus.lo !== m_lo || bus.done !== 1'b0) held = 1'b0;
            bus.a = $urandom;
            bus.b = $urandom;
            if (inj && n == 2) begin
                bus.start = 1'b1;
                bus.op = 3'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk({name, "_busy_cycles"}, 64'(n), 64'(en));
        chk({name, "_hold"}, 64'(held), 64'd1);
        chk({name, "_done"}, 64'(bus.done), 64'd1);
        chk({name, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({name, "_lo"}, 64'(bus.lo), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    // One-cycle request that must not start an operation (MTHI/MTLO/reserved).
    task automatic quick_op(input string name, input logic [2:0] o, input logic [31:0] x);
        bus.start = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = $urandom;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (o == 3'd4) m_hi = x;
        if (o == 3'd5) m_lo = x;
        chk({name, "_hi"}, 64'(bus.hi), 64'(m_hi));
        chk({name, "_lo"}, 64'(bus.lo), 64'(m_lo));
        chk({name, "_busy"}, 64'(bus.busy), 64'd0);
        chk({name, "_done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e;
        logic [2:0] o;
        logic [31:0] x, y;
        int sel;
        bit quiet;

        vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DC};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DC};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DC};
        vecs[5] = '{3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, DC};
        vecs[6] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};

        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.a = 32'h0;
        bus.b = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        #12;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        #11 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].n, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_low", i), 64'(bus.done), 64'd0);
        end

        // New MULTU issued in the done cycle of a DIVU.
        run_op("chain_divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DC, 1'b0);
        run_op("chain_multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, MC, 1'b0);
        @(posedge clk); #1;
        chk("chain_done_low", 64'(bus.done), 64'd0);

        // MTLO during RUN is dropped; lo ends as the product.
        run_op("mtlo_in_run", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, MC, 1'b1);
        @(posedge clk); #1;
        quick_op("mthi", 3'd4, 32'h1234);

        // Reset in RUN cycle 2 of a MULTU aborts it with no later done.
        bus.start = 1'b1;
        bus.op = 3'd1;
        bus.a = 32'hFFFFFFFF;
        bus.b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        #2 reset_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
        end
        chk("abort_quiet", 64'(quiet), 64'd1);

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) y = 32'h0;
            if (sel == 1) begin
                x = 32'h80000000;
                y = 32'hFFFFFFFF;
            end
            if (sel == 2) y = 32'($urandom_range(1, 9));
            if (o <= 3'd3) begin
                e = ref_md(o, x, y);
                run_op($sformatf("rnd%0d_op%0d", i, o), o, x, y, e[63:32], e[31:0],
                       (o < 3'd2) ? MC : DC, 1'($urandom_range(0, 1)));
                @(posedge clk); #1;
                chk($sformatf("rnd%0d_done_low", i), 64'(bus.done), 64'd0);
            end else begin
                quick_op($sformatf("rnd%0d_op%0d", i, o), o, x);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
